// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned OFFSET_W  = 2;
  localparam int unsigned BLOCK_W   = 128;
  // Byte offset bits inside one block (word offset plus byte-in-word).
  localparam int unsigned BLK_OFF_W = OFFSET_W + 2;
  // Widest tag any legal LINES setting can need; narrower tags are zero-extended.
  localparam int unsigned TAG_MAX_W = ADDR_W - BLK_OFF_W;

  typedef enum logic [1:0] {
    StIdle,
    StWriteback,
    StAllocate,
    StRefill
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_MAX_W-1:0] tag;
  } line_meta_t;

  // Select one 32-bit word out of a block; word 0 sits in the low bits.
  function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0]  blk,
                                                  input logic [OFFSET_W-1:0] off);
    return blk[off*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, metadata and data storage: combinational read, synchronous word and block write.
// Only valid/dirty bits are reset; tag and data contents are don't-care until refilled.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [$clog2(LINES)-1:0]   idx_i,
  output line_meta_t                 rd_meta_o,
  output logic [BLOCK_W-1:0]         rd_data_o,
  input  logic                       word_we_i,
  input  logic [OFFSET_W-1:0]        word_off_i,
  input  logic [WORD_W-1:0]          word_data_i,
  input  logic                       blk_we_i,
  input  logic [TAG_MAX_W-1:0]       blk_tag_i,
  input  logic [BLOCK_W-1:0]         blk_data_i
);

  logic [LINES-1:0]     valid_q, valid_d;
  logic [LINES-1:0]     dirty_q, dirty_d;
  logic [TAG_MAX_W-1:0] tag_q  [LINES];
  logic [TAG_MAX_W-1:0] tag_d  [LINES];
  logic [BLOCK_W-1:0]   data_q [LINES];
  logic [BLOCK_W-1:0]   data_d [LINES];

  // Next-state for the line arrays; a block fill always leaves the line clean.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (blk_we_i) begin
      valid_d[idx_i] = 1'b1;
      dirty_d[idx_i] = 1'b0;
      tag_d[idx_i]   = blk_tag_i;
      data_d[idx_i]  = blk_data_i;
    end else if (word_we_i) begin
      dirty_d[idx_i] = 1'b1;
      data_d[idx_i][word_off_i*WORD_W +: WORD_W] = word_data_i;
    end
  end

  // Valid/dirty registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data storage, never reset.
  always_ff @(posedge clk_i) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  // Combinational read port addressed by the CPU index.
  always_comb begin
    rd_meta_o.valid = valid_q[idx_i];
    rd_meta_o.dirty = dirty_q[idx_i];
    rd_meta_o.tag   = tag_q[idx_i];
    rd_data_o       = data_q[idx_i];
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller with memory watchdog.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned LINES       = 16,
  parameter int unsigned MEM_LAT_MAX = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cpu_req_i,
  input  logic               cpu_we_i,
  input  logic [ADDR_W-1:0]  cpu_addr_i,
  input  logic [WORD_W-1:0]  cpu_wdata_i,
  output logic [WORD_W-1:0]  cpu_rdata_o,
  output logic               cpu_stall_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [BLOCK_W-1:0] mem_wdata_o,
  input  logic [BLOCK_W-1:0] mem_rdata_i,
  input  logic               mem_ack_i,
`ifdef DCACHE_STATS_EN
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o,
`endif
  output logic               err_o
);

  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned WDOG_W = $clog2(MEM_LAT_MAX + 1);

  state_e               state_q, state_d;
  logic [WDOG_W-1:0]    wdog_q, wdog_d;
  logic                 err_q, err_d;
  logic [BLOCK_W-1:0]   fill_q, fill_d;

  logic [IDX_W-1:0]     cpu_idx;
  logic [OFFSET_W-1:0]  cpu_off;
  logic [TAG_MAX_W-1:0] cpu_tag;
  line_meta_t           meta;
  logic [BLOCK_W-1:0]   line_data;
  logic                 hit;
  logic                 word_we;
  logic                 blk_we;
  logic                 unused_addr_bits;

  assign cpu_idx          = cpu_addr_i[BLK_OFF_W +: IDX_W];
  assign cpu_off          = cpu_addr_i[2 +: OFFSET_W];
  assign cpu_tag          = TAG_MAX_W'(cpu_addr_i >> (BLK_OFF_W + IDX_W));
  assign hit              = meta.valid && (meta.tag == cpu_tag);
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  dcache_array #(
    .LINES (LINES)
  ) u_array (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (cpu_idx),
    .rd_meta_o   (meta),
    .rd_data_o   (line_data),
    .word_we_i   (word_we),
    .word_off_i  (cpu_off),
    .word_data_i (cpu_wdata_i),
    .blk_we_i    (blk_we),
    .blk_tag_i   (cpu_tag),
    .blk_data_i  (fill_q)
  );

  // Next-state and outputs; reset forces every output to its idle value.
  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    err_d       = err_q;
    fill_d      = fill_q;
    word_we     = 1'b0;
    blk_we      = 1'b0;
    cpu_rdata_o = '0;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req_i) begin
          if (hit) begin
            cpu_rdata_o = get_word(line_data, cpu_off);
            word_we     = cpu_we_i;
          end else begin
            cpu_stall_o = 1'b1;
            wdog_d      = '0;
            state_d     = (meta.valid && meta.dirty) ? StWriteback : StAllocate;
          end
        end
      end
      StWriteback: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        // Upper tag bits beyond the address width are always zero, so truncation is safe.
        mem_addr_o  = ADDR_W'({meta.tag, cpu_idx, {BLK_OFF_W{1'b0}}});
        mem_wdata_o = line_data;
        if (mem_ack_i) begin
          wdog_d  = '0;
          state_d = StAllocate;
        end else if (wdog_q == WDOG_W'(MEM_LAT_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StAllocate: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {cpu_addr_i[ADDR_W-1:BLK_OFF_W], {BLK_OFF_W{1'b0}}};
        if (mem_ack_i) begin
          fill_d  = mem_rdata_i;
          state_d = StRefill;
        end else if (wdog_q == WDOG_W'(MEM_LAT_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StRefill: begin
        cpu_stall_o = 1'b1;
        blk_we      = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rst_i) begin
      word_we     = 1'b0;
      blk_we      = 1'b0;
      cpu_rdata_o = '0;
      cpu_stall_o = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
    end
  end

  // Control state with synchronous reset; reset abandons any memory transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // Refill buffer holding the fetched block until it is written into the array.
  always_ff @(posedge clk_i) begin
    fill_q <= fill_d;
  end

  assign err_o = err_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // One count per IDLE request cycle; the re-hit after a refill counts as a hit.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == StIdle && cpu_req_i) begin
      if (hit) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  // Statistics registers, wrapping naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench: directed scenarios plus randomized accesses checked against
// an architectural memory model and a per-index tag map.
module tb_dcache_controller;

  localparam int unsigned LINES       = 16;
  localparam int unsigned MEM_LAT_MAX = 64;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_wdata_i = '0;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [127:0] mem_rdata_i;
  logic         mem_ack_i;
  logic         err_o;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  dcache_controller #(
    .LINES       (LINES),
    .MEM_LAT_MAX (MEM_LAT_MAX)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
`ifdef DCACHE_STATS_EN
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o),
`endif
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  // Memory responder controls and transaction log.
  int unsigned mem_lat   = 5;
  bit          ack_en    = 1'b1;
  bit          force_ack = 1'b0;
  int unsigned resp_cnt  = 0;
  bit          resp_chk  = 1'b0;
  int unsigned wb_cnt    = 0;
  int unsigned al_cnt    = 0;
  logic [31:0]  wb_addr  = '0;
  logic [31:0]  al_addr  = '0;
  logic [127:0] wb_data  = '0;

  // Backing memory and the value the CPU should observe, both word-addressed.
  logic [31:0] mem_words  [int unsigned];
  logic [31:0] arch_words [int unsigned];

  // Which block each index currently holds, and whether it differs from memory.
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  int unsigned m_tag   [LINES];

  function automatic logic [31:0] init_val(input int unsigned waddr);
    return (waddr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_get(input int unsigned waddr);
    if (!mem_words.exists(waddr)) mem_words[waddr] = init_val(waddr);
    return mem_words[waddr];
  endfunction

  function automatic logic [31:0] arch_get(input int unsigned waddr);
    if (!arch_words.exists(waddr)) arch_words[waddr] = init_val(waddr);
    return arch_words[waddr];
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Backing memory: acks mem_lat cycles after a request first appears.
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      #2;
      if (resp_chk) begin
        check("req_after_ack", mem_req_o, 1'b0);
        resp_chk = 1'b0;
      end
      mem_ack_i = 1'b0;
      if (force_ack) begin
        mem_ack_i = 1'b1;
        force_ack = 1'b0;
        resp_cnt  = 0;
      end else if (mem_req_o && ack_en) begin
        if (resp_cnt == mem_lat) begin
          mem_ack_i = 1'b1;
          resp_cnt  = 0;
          if (mem_we_o) begin
            wb_cnt++;
            wb_addr = mem_addr_o;
            wb_data = mem_wdata_o;
            for (int i = 0; i < 4; i++) mem_words[(mem_addr_o >> 2) + i] = mem_wdata_o[i*32 +: 32];
          end else begin
            al_cnt++;
            al_addr = mem_addr_o;
            for (int i = 0; i < 4; i++) mem_rdata_i[i*32 +: 32] = mem_get((mem_addr_o >> 2) + i);
            resp_chk = 1'b1;
          end
        end else begin
          resp_cnt++;
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // One CPU access held until the stall drops, checked against the models.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag);
    int unsigned  idx   = (addr >> 4) & (LINES - 1);
    int unsigned  tg    = addr >> 8;
    int unsigned  waddr = addr >> 2;
    bit           hit   = m_valid[idx] && (m_tag[idx] == tg);
    bit           evict = !hit && m_valid[idx] && m_dirty[idx];
    int unsigned  exp_stall = hit ? 0 : (evict ? 2 * mem_lat + 4 : mem_lat + 3);
    int unsigned  wb0 = wb_cnt;
    int unsigned  al0 = al_cnt;
    int unsigned  stalls = 0;
    logic [31:0]  exp_wb_addr = (m_tag[idx] << 8) | (idx << 4);
    logic [127:0] exp_wb = '0;
    if (evict) begin
      for (int k = 0; k < 4; k++) exp_wb[k*32 +: 32] = arch_get((exp_wb_addr >> 2) + k);
    end
    @(negedge clk_i);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    #1;
    while (cpu_stall_o === 1'b1 && stalls < 300) begin
      @(negedge clk_i);
      #1;
      stalls++;
    end
    check({tag, "_stall_cycles"}, stalls, exp_stall);
    check({tag, "_mem_req_idle"}, mem_req_o, 1'b0);
    check({tag, "_wb_count"}, wb_cnt - wb0, evict ? 1 : 0);
    check({tag, "_alloc_count"}, al_cnt - al0, hit ? 0 : 1);
    if (evict) begin
      check({tag, "_wb_addr"}, wb_addr, exp_wb_addr);
      check({tag, "_wb_data"}, wb_data, exp_wb);
    end
    if (!hit) check({tag, "_alloc_addr"}, al_addr, addr & 32'hFFFF_FFF0);
    if (!we) check({tag, "_rdata"}, cpu_rdata_o, arch_get(waddr));
    else arch_words[waddr] = wdata;
    m_dirty[idx] = (hit ? m_dirty[idx] : 1'b0) | we;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
  endtask

  task automatic idle_cycle();
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    #1;
    check("idle_stall", cpu_stall_o, 1'b0);
    check("idle_mem_req", mem_req_o, 1'b0);
  endtask

  // Model view of reset: lines invalid, unwritten-back stores are lost.
  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    arch_words = mem_words;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i      = 1'b1;
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h40;
    #1;
    check("rst_stall", cpu_stall_o, 1'b0);
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_mem_we", mem_we_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_wdata", mem_wdata_o, 128'h0);
    check("rst_rdata", cpu_rdata_o, 32'h0);
    @(negedge clk_i);
    #1;
    check("rst_err", err_o, 1'b0);
    @(negedge clk_i);
    rst_i     = 1'b0;
    cpu_req_i = 1'b0;
    #1;
    check("post_rst_stall", cpu_stall_o, 1'b0);
    model_reset();
  endtask

  initial begin
    int unsigned k;
    do_reset();

    // Cold load: clean miss, latency 5.
    mem_lat = 5;
    access(1'b0, 32'h0000_0040, 32'h0, "cold_load_40");
    check("cold_load_word0", cpu_rdata_o, init_val(32'h40 >> 2));

    // Store hit then load back.
    access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, "store_hit_44");
    access(1'b0, 32'h0000_0044, 32'h0, "load_hit_44");
    check("load_44_value", cpu_rdata_o, 32'hDEAD_BEEF);

    // Conflict with a dirty line: write-back of the old block first.
    access(1'b0, 32'h0000_0140, 32'h0, "dirty_evict_140");
    check("evict_wb_addr", wb_addr, 32'h40);
    check("evict_wb_word1", wb_data[63:32], 32'hDEAD_BEEF);
    check("evict_alloc_addr", al_addr, 32'h140);
    idle_cycle();

    // Random traffic over 4 tags x 16 indices with varying memory latency.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      mem_lat = $urandom_range(1, 6);
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      access(1'($urandom_range(0, 1)), a, $urandom, "rand");
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    check("no_err_after_random", err_o, 1'b0);

    // Reset in the middle of ALLOCATE, then a stray ack.
    mem_lat = 3;
    access(1'b0, 32'h0000_0040, 32'h0, "reload_40");
    ack_en = 1'b0;
    @(negedge clk_i);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_1140;
    repeat (3) @(negedge clk_i);
    #1;
    check("alloc_mid_req", mem_req_o, 1'b1);
    check("alloc_mid_we", mem_we_o, 1'b0);
    check("alloc_mid_addr", mem_addr_o, 32'h0000_1140);
    @(negedge clk_i);
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    rst_i     = 1'b0;
    force_ack = 1'b1;
    model_reset();
    #3;
    check("stray_ack_req", mem_req_o, 1'b0);
    check("stray_ack_stall", cpu_stall_o, 1'b0);
    @(negedge clk_i);
    #3;
    check("after_stray_req", mem_req_o, 1'b0);
    check("after_stray_stall", cpu_stall_o, 1'b0);
    ack_en = 1'b1;
    access(1'b0, 32'h0000_0040, 32'h0, "remiss_40");

    // Watchdog: no ack at all.
    ack_en = 1'b0;
    @(negedge clk_i);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0080;
    @(negedge clk_i);
    #1;
    check("wdog_first_req", mem_req_o, 1'b1);
    k = 0;
    while (err_o !== 1'b1 && k < 200) begin
      @(negedge clk_i);
      #1;
      k++;
    end
    check("wdog_cycles", k, MEM_LAT_MAX);
    check("wdog_err", err_o, 1'b1);
    check("wdog_req_dropped", mem_req_o, 1'b0);
    cpu_req_i = 1'b0;
    ack_en    = 1'b1;
    access(1'b0, 32'h0000_0080, 32'h0, "after_wdog_80");
    check("err_sticky", err_o, 1'b1);

    do_reset();
`ifdef DCACHE_STATS_EN
    check("stats_rst_hit", hit_cnt_o, 32'd0);
    check("stats_rst_miss", miss_cnt_o, 32'd0);
`endif
    access(1'b0, 32'h0000_0200, 32'h0, "stats_miss");
    access(1'b0, 32'h0000_0204, 32'h0, "stats_hit1");
    access(1'b0, 32'h0000_0208, 32'h0, "stats_hit2");
    access(1'b0, 32'h0000_020C, 32'h0, "stats_hit3");
    idle_cycle();
`ifdef DCACHE_STATS_EN
    check("stats_hit", hit_cnt_o, 32'd4);
    check("stats_miss", miss_cnt_o, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish within bound");
    $fatal(1, "timeout");
  end

endmodule
